// File: rtl/writeback_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_scheduler
//  Purpose  : Buffers one result per execution unit (ALU, COMP, MISC, JMP)
//             and grants the shared writeback bus round-robin. The bus
//             owner, data and destination are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_scheduler #(
    parameter int DATA_SIZE     = 16,
    parameter int REG_ADDR_SIZE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [DATA_SIZE-1:0]     alu_data,
    input  logic [REG_ADDR_SIZE-1:0] alu_dest,

    input  logic                     comp_valid,
    output logic                     comp_ready,
    input  logic [DATA_SIZE-1:0]     comp_data,
    input  logic [REG_ADDR_SIZE-1:0] comp_dest,

    input  logic                     misc_valid,
    output logic                     misc_ready,
    input  logic [DATA_SIZE-1:0]     misc_data,
    input  logic [REG_ADDR_SIZE-1:0] misc_dest,

    input  logic                     jmp_valid,
    output logic                     jmp_ready,

    input  logic                     wb_ready,

    output logic                     alu_cs,
    output logic                     comp_cs,
    output logic                     misc_cs,
    output logic                     jmp_cs,
    output logic [DATA_SIZE-1:0]     bus_data,
    output logic [REG_ADDR_SIZE-1:0] wb_dest,
    output logic                     wb_en
);

    localparam logic [1:0] c_IDX_JMP = 2'd3;

    // Slot state: index 0=ALU, 1=COMP, 2=MISC, 3=JMP (jump slot has no payload)
    logic [3:0]               full_q, full_d;
    logic [DATA_SIZE-1:0]     data_q [0:2];
    logic [DATA_SIZE-1:0]     data_d [0:2];
    logic [REG_ADDR_SIZE-1:0] dest_q [0:2];
    logic [REG_ADDR_SIZE-1:0] dest_d [0:2];

    // Output stage: one-hot owner doubles as the valid flag (all zero = idle)
    logic [3:0]               cs_q, cs_d;
    logic [DATA_SIZE-1:0]     bdata_q, bdata_d;
    logic [REG_ADDR_SIZE-1:0] bdest_q, bdest_d;
    logic [1:0]               ptr_q, ptr_d;

    logic                     w_out_valid;
    logic                     w_advance;
    logic                     w_gnt_vld;
    logic [1:0]               w_gnt_idx;
    logic [1:0]               w_scan;
    logic                     w_take;
    logic [3:0]               w_gnt_oh;
    logic [3:0]               w_valid;
    logic [3:0]               w_ready;
    logic [DATA_SIZE-1:0]     w_gnt_data;
    logic [REG_ADDR_SIZE-1:0] w_gnt_dest;

    assign w_out_valid = |cs_q;
    assign w_advance   = !w_out_valid || wb_ready;
    assign w_valid     = {jmp_valid, misc_valid, comp_valid, alu_valid};

    // Round-robin pick: first full slot at ptr, ptr+1, ... (reverse scan so
    // the smallest offset is the last, winning, assignment)
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = ptr_q;
        w_scan    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            w_scan = ptr_q + 2'(k);
            if (full_q[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    assign w_take   = w_gnt_vld && w_advance;
    assign w_gnt_oh = w_take ? (4'b0001 << w_gnt_idx) : 4'b0000;

    // A slot can take a new result when empty or being drained this cycle
    assign w_ready  = flush ? 4'b0000 : (~full_q | w_gnt_oh);

    assign alu_ready  = w_ready[0];
    assign comp_ready = w_ready[1];
    assign misc_ready = w_ready[2];
    assign jmp_ready  = w_ready[3];

    // Payload of the granted slot; jump carries none
    always_comb begin
        w_gnt_data = '0;
        w_gnt_dest = '0;
        case (w_gnt_idx)
            2'd0:    begin w_gnt_data = data_q[0]; w_gnt_dest = dest_q[0]; end
            2'd1:    begin w_gnt_data = data_q[1]; w_gnt_dest = dest_q[1]; end
            2'd2:    begin w_gnt_data = data_q[2]; w_gnt_dest = dest_q[2]; end
            default: begin w_gnt_data = '0;        w_gnt_dest = '0;        end
        endcase
    end

    // Next-state: slot fill/drain, output stage load, pointer update, flush
    always_comb begin
        full_d  = full_q & ~w_gnt_oh;
        data_d  = data_q;
        dest_d  = dest_q;
        cs_d    = cs_q;
        bdata_d = bdata_q;
        bdest_d = bdest_q;
        ptr_d   = ptr_q;

        if (w_advance) begin
            if (w_take) begin
                cs_d    = w_gnt_oh;
                bdata_d = (w_gnt_idx == c_IDX_JMP) ? '0 : w_gnt_data;
                bdest_d = (w_gnt_idx == c_IDX_JMP) ? '0 : w_gnt_dest;
                ptr_d   = w_gnt_idx + 2'd1;
            end else begin
                cs_d    = '0;
                bdata_d = '0;
                bdest_d = '0;
            end
        end

        if (w_valid[0] && w_ready[0]) begin
            full_d[0] = 1'b1;
            data_d[0] = alu_data;
            dest_d[0] = alu_dest;
        end
        if (w_valid[1] && w_ready[1]) begin
            full_d[1] = 1'b1;
            data_d[1] = comp_data;
            dest_d[1] = comp_dest;
        end
        if (w_valid[2] && w_ready[2]) begin
            full_d[2] = 1'b1;
            data_d[2] = misc_data;
            dest_d[2] = misc_dest;
        end
        if (w_valid[3] && w_ready[3]) begin
            full_d[3] = 1'b1;
        end

        if (flush) begin
            full_d  = '0;
            cs_d    = '0;
            bdata_d = '0;
            bdest_d = '0;
            ptr_d   = ptr_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= '0;
            data_q  <= '{default: '0};
            dest_q  <= '{default: '0};
            cs_q    <= '0;
            bdata_q <= '0;
            bdest_q <= '0;
            ptr_q   <= '0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            cs_q    <= cs_d;
            bdata_q <= bdata_d;
            bdest_q <= bdest_d;
            ptr_q   <= ptr_d;
        end
    end

    assign alu_cs   = cs_q[0];
    assign comp_cs  = cs_q[1];
    assign misc_cs  = cs_q[2];
    assign jmp_cs   = cs_q[3];
    assign bus_data = bdata_q;
    assign wb_dest  = bdest_q;
    assign wb_en    = w_out_valid && !cs_q[3];

endmodule
`default_nettype wire

// File: tb/tb_writeback_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_scheduler
//  Purpose  : Directed stimulus with a scoreboard of expected bus transfers;
//             a monitor pops and compares on every consumed bus beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_scheduler;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, wb_ready;
    logic          alu_valid, comp_valid, misc_valid, jmp_valid;
    logic          alu_ready, comp_ready, misc_ready, jmp_ready;
    logic [DW-1:0] alu_data, comp_data, misc_data;
    logic [AW-1:0] alu_dest, comp_dest, misc_dest;
    logic          alu_cs, comp_cs, misc_cs, jmp_cs, wb_en;
    logic [DW-1:0] bus_data;
    logic [AW-1:0] wb_dest;

    writeback_scheduler #(.DATA_SIZE(DW), .REG_ADDR_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_dest(alu_dest),
        .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_data(comp_data), .comp_dest(comp_dest),
        .misc_valid(misc_valid), .misc_ready(misc_ready), .misc_data(misc_data), .misc_dest(misc_dest),
        .jmp_valid(jmp_valid), .jmp_ready(jmp_ready),
        .wb_ready(wb_ready),
        .alu_cs(alu_cs), .comp_cs(comp_cs), .misc_cs(misc_cs), .jmp_cs(jmp_cs),
        .bus_data(bus_data), .wb_dest(wb_dest), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    cs;   // {jmp, misc, comp, alu}
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic push(input int own, input logic [DW-1:0] d, input logic [AW-1:0] de);
        exp_t e;
        e.cs   = 4'b0001 << own;
        e.data = (own == 3) ? '0 : d;
        e.dest = (own == 3) ? '0 : de;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; comp_valid = 1'b0; misc_valid = 1'b0; jmp_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wb_ready = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_cs"},   {jmp_cs, misc_cs, comp_cs, alu_cs}, 4'b0000);
        chk({tag, "_data"}, bus_data, 16'h0000);
        chk({tag, "_dest"}, wb_dest, 4'h0);
        chk({tag, "_wben"}, wb_en, 1'b0);
    endtask

    // Monitor: every beat consumed by the writeback stage must match the head
    always @(negedge clk) begin
        if (rst_n && wb_ready && (alu_cs || comp_cs || misc_cs || jmp_cs)) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_beat", {jmp_cs, misc_cs, comp_cs, alu_cs}, 4'b0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_cs",   {jmp_cs, misc_cs, comp_cs, alu_cs}, e.cs);
                chk("mon_data", bus_data, e.data);
                chk("mon_dest", wb_dest, e.dest);
                chk("mon_wben", wb_en, !e.cs[3]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt [4];
        logic [3:0] rdy;
        logic [3:0] vld;

        rst_n = 1'b0; wb_ready = 1'b1; idle_inputs();
        alu_data = '0; comp_data = '0; misc_data = '0;
        alu_dest = '0; comp_dest = '0; misc_dest = '0;

        // ---- 1: reset state and single ALU transfer with two-cycle latency
        do_reset();
        #1;
        check_idle("reset");
        chk("reset_ready", {jmp_ready, misc_ready, comp_ready, alu_ready}, 4'b1111);
        alu_valid = 1'b1; alu_data = 16'h1234; alu_dest = 4'd3;
        push(0, 16'h1234, 4'd3);
        #1 chk("t1_alu_ready", alu_ready, 1'b1);
        cyc(); alu_valid = 1'b0;
        #1 chk("t1_not_early", alu_cs, 1'b0);
        cyc();
        chk("t1_alu_cs", alu_cs, 1'b1);
        chk("t1_data", bus_data, 16'h1234);
        chk("t1_dest", wb_dest, 4'd3);
        chk("t1_wben", wb_en, 1'b1);
        cyc();
        check_idle("t1_idle");

        // ---- 2: all four units contend, two results each, round-robin order
        do_reset();
        for (int u = 0; u < 4; u++) cnt[u] = 0;
        push(0, 16'hA000, 4'd1); push(1, 16'hC000, 4'd2); push(2, 16'hD000, 4'd4); push(3, 0, 0);
        push(0, 16'hA001, 4'd1); push(1, 16'hC001, 4'd2); push(2, 16'hD001, 4'd4); push(3, 0, 0);
        for (int t = 0; t < 12; t++) begin
            vld = {cnt[3] < 2, cnt[2] < 2, cnt[1] < 2, cnt[0] < 2};
            alu_valid = vld[0];  alu_data  = 16'hA000 + DW'(cnt[0]); alu_dest  = 4'd1;
            comp_valid = vld[1]; comp_data = 16'hC000 + DW'(cnt[1]); comp_dest = 4'd2;
            misc_valid = vld[2]; misc_data = 16'hD000 + DW'(cnt[2]); misc_dest = 4'd4;
            jmp_valid = vld[3];
            #1;
            rdy = {jmp_ready, misc_ready, comp_ready, alu_ready};
            if (t == 5) chk("t2_jmp_cycle_cs", {jmp_cs, wb_en}, 2'b10);
            for (int u = 0; u < 4; u++) if (vld[u] && rdy[u]) cnt[u]++;
            cyc();
        end
        chk("t2_all_accepted", cnt[0] + cnt[1] + cnt[2] + cnt[3], 8);
        idle_inputs();

        // ---- 3: stall holds the bus; MISC accepted once while stalled
        do_reset();
        comp_valid = 1'b1; comp_data = 16'hBEEF; comp_dest = 4'd5;
        push(1, 16'hBEEF, 4'd5);
        cyc(); comp_valid = 1'b0;
        cyc();
        wb_ready = 1'b0;
        misc_valid = 1'b1; misc_data = 16'h0042; misc_dest = 4'd7;
        push(2, 16'h0042, 4'd7);
        #1;
        chk("t3_misc_ready", misc_ready, 1'b1);
        chk("t3_comp_cs", comp_cs, 1'b1);
        for (int s = 0; s < 2; s++) begin
            cyc();
            misc_valid = 1'b0;
            #1;
            chk("t3_misc_blocked", misc_ready, 1'b0);
            chk("t3_hold_cs", {jmp_cs, misc_cs, comp_cs, alu_cs}, 4'b0010);
            chk("t3_hold_data", bus_data, 16'hBEEF);
            chk("t3_hold_dest", wb_dest, 4'd5);
        end
        cyc();
        wb_ready = 1'b1;
        #1 chk("t3_release_data", bus_data, 16'hBEEF);
        cyc();
        chk("t3_misc_cs", misc_cs, 1'b1);
        chk("t3_misc_data", bus_data, 16'h0042);
        cyc();
        check_idle("t3_idle");

        // ---- 4: back-to-back ALU stream, one beat per cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            alu_valid = (k < 4);
            alu_data  = DW'(k + 1);
            alu_dest  = AW'(k + 8);
            if (k < 4) push(0, DW'(k + 1), AW'(k + 8));
            #1;
            if (k < 4) chk("t4_alu_ready", alu_ready, 1'b1);
            if (k >= 2) chk("t4_stream_data", bus_data, DW'(k - 1));
            cyc();
        end
        idle_inputs();

        // ---- 5: flush discards slots and the stalled bus beat
        do_reset();
        alu_valid = 1'b1; alu_data = 16'h5555; alu_dest = 4'd8;
        misc_valid = 1'b1; misc_data = 16'h6666; misc_dest = 4'd9;
        cyc();
        misc_valid = 1'b0;
        alu_data = 16'h7777;
        #1;
        chk("t5_ready_pre", {misc_ready, alu_ready}, 2'b01);
        cyc();
        alu_valid = 1'b0;
        flush = 1'b1;
        wb_ready = 1'b0;
        #1;
        chk("t5_bus_busy", alu_cs, 1'b1);
        chk("t5_flush_ready", {jmp_ready, misc_ready, comp_ready, alu_ready}, 4'b0000);
        cyc();
        flush = 1'b0;
        wb_ready = 1'b1;
        #1;
        check_idle("t5_post");
        chk("t5_post_ready", {jmp_ready, misc_ready, comp_ready, alu_ready}, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_idle("t5_drained");
        end

        // ---- 6: reset mid-transfer with ptr=2, then ALU wins over COMP
        do_reset();
        comp_valid = 1'b1; comp_data = 16'h9999; comp_dest = 4'd6;
        cyc(); comp_valid = 1'b0;
        cyc();
        wb_ready = 1'b0;
        rst_n = 1'b0;
        #1 chk("t6_busy", comp_cs, 1'b1);
        cyc();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        #1;
        check_idle("t6_reset");
        chk("t6_ready", {jmp_ready, misc_ready, comp_ready, alu_ready}, 4'b1111);
        alu_valid = 1'b1; alu_data = 16'h1111; alu_dest = 4'd1;
        comp_valid = 1'b1; comp_data = 16'h2222; comp_dest = 4'd2;
        push(0, 16'h1111, 4'd1);
        push(1, 16'h2222, 4'd2);
        cyc();
        idle_inputs();
        cyc();
        chk("t6_alu_first", {comp_cs, alu_cs}, 2'b01);
        chk("t6_alu_data", bus_data, 16'h1111);
        cyc();
        chk("t6_comp_second", {comp_cs, alu_cs}, 2'b10);
        chk("t6_comp_data", bus_data, 16'h2222);
        cyc();
        check_idle("t6_idle");

        cyc(); cyc();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
